// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, branch/jump redirect, stall hold,
// level-request handshake to instruction memory, null-op halt and a
// saturating count of instructions consumed by decode.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h00400000,
    parameter int                COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                mem_req,
    output logic [ADDR_W-3:0]   mem_addr,
    input  logic                mem_ready,
    input  logic [INST_W-1:0]   mem_rdata,
    output logic                inst_valid,
    output logic [INST_W-1:0]   inst,
    output logic [ADDR_W-1:0]   inst_pc,
    output logic                halt,
    output logic [COUNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc, pc_nx;
    logic [INST_W-1:0]   inst_nx;
    logic [ADDR_W-1:0]   inst_pc_nx;
    logic                inst_valid_nx;
    logic                halt_nx;
    logic [COUNT_W-1:0]  fetch_count_nx;
    logic [ADDR_W-1:0]   redirect_target;
    logic                consume;

    // Redirect target is word aligned; the low two address bits are dropped.
    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign consume         = inst_valid && !stall;

    assign mem_req  = (state == FETCH) && rst_n;
    assign mem_addr = pc[ADDR_W-1:2];

    // Next-state and next-datapath values; redirect outranks everything except HALT.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        inst_nx        = inst;
        inst_pc_nx     = inst_pc;
        inst_valid_nx  = inst_valid;
        halt_nx        = halt;
        fetch_count_nx = fetch_count;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_nx         = redirect_target;
                    inst_valid_nx = 1'b0;
                end else if (mem_ready) begin
                    if (mem_rdata != '0) begin
                        inst_nx       = mem_rdata;
                        inst_pc_nx    = pc;
                        inst_valid_nx = 1'b1;
                        pc_nx         = pc + ADDR_W'(4);
                        state_nx      = HOLD;
                    end else begin
                        halt_nx  = 1'b1;
                        state_nx = HALT;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nx         = redirect_target;
                    inst_valid_nx = 1'b0;
                    state_nx      = FETCH;
                end else if (consume) begin
                    inst_valid_nx = 1'b0;
                    if (fetch_count != '1)
                        fetch_count_nx = fetch_count + 1'b1;
                    state_nx = FETCH;
                end
            end
            HALT: begin
                inst_valid_nx = 1'b0;
                halt_nx       = 1'b1;
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inst        <= '0;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
            halt        <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            inst        <= inst_nx;
            inst_pc     <= inst_pc_nx;
            inst_valid  <= inst_valid_nx;
            halt        <= halt_nx;
            fetch_count <= fetch_count_nx;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: default instance plus a
// wrap/saturation instance (RESET_PC at top of memory, 2-bit counter).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halt;
    logic [15:0] fetch_count;

    logic        w_mem_req;
    logic [29:0] w_mem_addr;
    logic        w_mem_ready;
    logic [31:0] w_mem_rdata;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_halt;
    logic [1:0]  w_fetch_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .halt(halt), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC), .COUNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ready(w_mem_ready), .mem_rdata(w_mem_rdata),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .halt(w_halt), .fetch_count(w_fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_ready = 1'b0; mem_rdata = '0; w_mem_ready = 1'b0; w_mem_rdata = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // Fetch one word at exp_pc after `lat` wait cycles, then let decode consume it.
    task automatic fetch_and_consume(input int lat, input logic [31:0] data, input logic [31:0] exp_pc);
        for (int i = 0; i < lat; i++) begin
            mem_ready = 1'b0;
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL wait_req got=%b exp=1", mem_req); end
            checks++; if (mem_addr !== exp_pc[31:2]) begin failures++; $display("FAIL wait_addr got=%h exp=%h", mem_addr, exp_pc[31:2]); end
            checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL wait_valid got=%b exp=0", inst_valid); end
            step();
        end
        mem_ready = 1'b1; mem_rdata = data;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== exp_pc[31:2]) begin failures++; $display("FAIL addr got=%h exp=%h", mem_addr, exp_pc[31:2]); end
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%b exp=1", inst_valid); end
        checks++; if (inst !== data) begin failures++; $display("FAIL cap_inst got=%h exp=%h", inst, data); end
        checks++; if (inst_pc !== exp_pc) begin failures++; $display("FAIL cap_pc got=%h exp=%h", inst_pc, exp_pc); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hold_req got=%b exp=0", mem_req); end
        step();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL pulse_end got=%b exp=0", inst_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_ready = 1'b0; mem_rdata = '0; w_mem_ready = 1'b0; w_mem_rdata = '0;
        step();
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%b exp=0", halt); end
        checks++; if (fetch_count !== 16'h0) begin failures++; $display("FAIL rst_count got=%h exp=0", fetch_count); end
        checks++; if (mem_addr !== 30'h00100000) begin failures++; $display("FAIL rst_addr got=%h exp=00100000", mem_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_release_req got=%b exp=1", mem_req); end
    endtask

    task automatic test_basic();
        do_reset();
        fetch_and_consume(0, 32'h20080001, 32'h00400000);
        checks++; if (fetch_count !== 16'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", fetch_count); end
        fetch_and_consume(0, 32'h20090002, 32'h00400004);
        checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL basic_count2 got=%0d exp=2", fetch_count); end
        mem_ready = 1'b1; mem_rdata = 32'h0;
        checks++; if (mem_addr !== 30'h00100002) begin failures++; $display("FAIL basic_addr3 got=%h exp=00100002", mem_addr); end
        step();
        mem_ready = 1'b0;
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL basic_halt got=%b exp=1", halt); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL basic_halt_valid got=%b exp=0", inst_valid); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL basic_halt_req got=%b exp=0", mem_req); end
        redirect_valid = 1'b1; redirect_pc = 32'h00400100;
        step();
        step();
        redirect_valid = 1'b0;
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_redirect_halt got=%b exp=1", halt); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL halt_redirect_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 30'h00100002) begin failures++; $display("FAIL halt_redirect_addr got=%h exp=00100002", mem_addr); end
        checks++; if (fetch_count !== 16'd2) begin failures++; $display("FAIL halt_count got=%0d exp=2", fetch_count); end
    endtask

    task automatic test_latency();
        do_reset();
        fetch_and_consume(3, 32'h11111111, 32'h00400000);
        fetch_and_consume(3, 32'h22222222, 32'h00400004);
        fetch_and_consume(3, 32'h33333333, 32'h00400008);
        checks++; if (fetch_count !== 16'd3) begin failures++; $display("FAIL lat_count got=%0d exp=3", fetch_count); end
        checks++; if (mem_addr !== 30'h00100003) begin failures++; $display("FAIL lat_next_addr got=%h exp=00100003", mem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h8C020000;
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", inst_valid); end
            checks++; if (inst !== 32'h8C020000) begin failures++; $display("FAIL stall_inst got=%h exp=8c020000", inst); end
            checks++; if (inst_pc !== 32'h00400000) begin failures++; $display("FAIL stall_pc got=%h exp=00400000", inst_pc); end
            checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%b exp=0", mem_req); end
            checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL stall_count got=%0d exp=0", fetch_count); end
        end
        stall = 1'b0;
        step();
        checks++; if (fetch_count !== 16'd1) begin failures++; $display("FAIL unstall_count got=%0d exp=1", fetch_count); end
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL unstall_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 30'h00100001) begin failures++; $display("FAIL unstall_addr got=%h exp=00100001", mem_addr); end
    endtask

    task automatic test_redirect();
        do_reset();
        stall = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h00400103;
        step();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_hold_valid got=%b exp=0", inst_valid); end
        checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL redir_hold_count got=%0d exp=0", fetch_count); end
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL redir_hold_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 30'h00100040) begin failures++; $display("FAIL redir_hold_addr got=%h exp=00100040", mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h0;
        step();
        redirect_valid = 1'b0; mem_ready = 1'b0;
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL redir_fetch_halt got=%b exp=0", halt); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_fetch_valid got=%b exp=0", inst_valid); end
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL redir_fetch_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 30'h00100040) begin failures++; $display("FAIL redir_fetch_addr got=%h exp=00100040", mem_addr); end
        fetch_and_consume(0, 32'h8C030004, 32'h00400100);
        checks++; if (fetch_count !== 16'd1) begin failures++; $display("FAIL redir_count got=%0d exp=1", fetch_count); end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        checks++; if (w_mem_addr !== 30'h3FFFFFFF) begin failures++; $display("FAIL wrap_addr0 got=%h exp=3fffffff", w_mem_addr); end
        for (int i = 0; i < 5; i++) begin
            w_mem_ready = 1'b1; w_mem_rdata = 32'h00000013;
            step();
            w_mem_ready = 1'b0; w_mem_rdata = '0;
            if (i == 0) begin
                checks++; if (w_inst_pc !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_inst_pc got=%h exp=fffffffc", w_inst_pc); end
            end
            step();
            if (i == 0) begin
                checks++; if (w_mem_addr !== 30'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0", w_mem_addr); end
            end
            if (i == 2) begin
                checks++; if (w_fetch_count !== 2'd3) begin failures++; $display("FAIL sat_count3 got=%0d exp=3", w_fetch_count); end
            end
        end
        checks++; if (w_fetch_count !== 2'd3) begin failures++; $display("FAIL sat_count5 got=%0d exp=3", w_fetch_count); end
        checks++; if (w_mem_addr !== 30'h4) begin failures++; $display("FAIL wrap_addr5 got=%h exp=4", w_mem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b1; mem_rdata = 32'h0;
        step();
        mem_ready = 1'b0;
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL mid_halt_pre got=%b exp=1", halt); end
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h00400200;
        step();
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL mid_halt_rst got=%b exp=0", halt); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL mid_halt_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 30'h00100000) begin failures++; $display("FAIL mid_halt_addr got=%h exp=00100000", mem_addr); end
        rst_n = 1'b1; redirect_valid = 1'b0;
        #1;
        fetch_and_consume(0, 32'h20080001, 32'h00400000);
        step();
        rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h20090002;
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL mid_req_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL mid_req_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL mid_req_pc got=%h exp=0", inst_pc); end
        checks++; if (fetch_count !== 16'd0) begin failures++; $display("FAIL mid_req_count got=%0d exp=0", fetch_count); end
        checks++; if (mem_addr !== 30'h00100000) begin failures++; $display("FAIL mid_req_addr got=%h exp=00100000", mem_addr); end
        rst_n = 1'b1;
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL resume_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 30'h00100000) begin failures++; $display("FAIL resume_addr got=%h exp=00100000", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_stall();
        test_redirect();
        test_wrap_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch unit: PC register, PC+4 sequencing, branch/jump redirect, stall back-pressure and a valid/ready handshake to a variable-latency instruction memory. Sits between the instruction memory and decode. Detects the null op (all-zero word) and halts fetch. Keeps a delivered-instruction counter for the bench and perf checks.

Parameters:
ADDR_W, 32, byte-address width of PC, redirect_pc and inst_pc
INST_W, 32, instruction word width
RESET_PC, 32'h00400000, PC value loaded on reset (low two bits zero)
COUNT_W, 16, width of fetch_count (saturating)

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
stall  input  1  decode not ready; holds the current instruction
redirect_valid  input  1  load redirect_pc this cycle (branch/jump)
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
mem_req  output  1  fetch request to memory
mem_addr  output  ADDR_W-2  word address = pc[ADDR_W-1:2]
mem_ready  input  1  memory returns mem_rdata this cycle
mem_rdata  input  INST_W  instruction word
inst_valid  output  1  inst/inst_pc hold a valid instruction
inst  output  INST_W  fetched instruction
inst_pc  output  ADDR_W  byte address of inst
halt  output  1  null op fetched; fetch stopped
fetch_count  output  COUNT_W  instructions consumed by decode

Behaviour:
- States: FETCH, HOLD, HALT. Reset: state=FETCH, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halt=0, fetch_count=0. mem_req=0 while rst_n=0.
- mem_req = (state==FETCH) && rst_n; mem_addr = pc[ADDR_W-1:2], stable while in FETCH without redirect.
- FETCH, mem_ready=1, mem_rdata!=0: inst<=mem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (mod 2^ADDR_W; 0xFFFFFFFC wraps to 0), ->HOLD. Latency: inst_valid rises the cycle after mem_ready.
- FETCH, mem_ready=1, mem_rdata==0: ->HALT, halt<=1, inst_valid stays 0, pc unchanged.
- FETCH, mem_ready=0: remain, mem_req held high, address held.
- HOLD: consume = inst_valid && !stall. On consume: inst_valid<=0, fetch_count<=fetch_count+1 (saturate at all-ones), ->FETCH. With stall=1: inst, inst_pc, inst_valid held unchanged indefinitely.
- Redirect (any state except HALT) has highest priority: pc<={redirect_pc[ADDR_W-1:2],2'b00}, inst_valid<=0, ->FETCH. An instruction in HOLD is discarded without counting, even if stall=0 that cycle. In FETCH, a same-cycle mem_ready/mem_rdata is discarded (no capture, no halt, even if mem_rdata==0). Memory is a level-request responder; the address changing mid-request is legal.
- HALT: mem_req=0, inst_valid=0, halt=1; redirect and stall ignored; exit only via reset.
- Reset mid-operation (any state, including mid-request or HALT): all state returns to reset values on that posedge; reset dominates redirect.
- No X on outputs after reset; inst/inst_pc retain their last captured values when inst_valid=0.

Test Plan:
- Reset then 1-cycle-latency memory returning 0x20080001,0x20090002,0x00000000, stall=0 -> mem_addr 0x00100000,0x00100001,0x00100002; inst_pc 0x00400000,0x00400004; halt=1 after third word; fetch_count=2; mem_req=0 afterwards.
- mem_ready delayed 3 cycles per request -> mem_req and mem_addr stable 3 cycles, one inst_valid pulse per word, no duplicated or skipped PC.
- Hold stall=1 for 5 cycles with inst 0x8C020000 valid -> inst/inst_pc unchanged, no new mem_req, fetch_count unchanged; stall drop -> count+1, next request at pc+4.
- redirect_valid with redirect_pc=0x00400103 during HOLD, and again in FETCH coinciding with mem_ready and mem_rdata=0 -> held inst dropped uncounted, next mem_addr=0x00100040, no halt.
- RESET_PC=32'hFFFFFFFC -> second fetch mem_addr=0; COUNT_W=2 -> fetch_count saturates at 3.
- rst_n low during HALT and during an outstanding request -> outputs return to reset values on that edge; fetch resumes at RESET_PC.
